// File: rtl/enc_pack_sched_pkg.sv
// Shared encoder definitions: default geometry of the binder-pack array and
// the pack-sequencer state encoding.
package enc_pack_sched_pkg;

    localparam int NUM_PACKS_DEF       = 8;
    localparam int FEATURES_PER_CC_DEF = 62;
    localparam int BIND_LAT_DEF        = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/enc_lat_pipe.sv
// Binding-latency tracker: a DEPTH-deep shift register of {valid, pack index}.
// The last stage is what the accumulator consumes this cycle; pend_any flags
// entries still in flight behind it, so the sequencer knows when draining ends.
module enc_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             pend_any
);

    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

    // Shift one stage per cycle; a flush drops every in-flight entry.
    always_comb begin
        vld_d    = '0;
        idx_d    = idx_q;
        vld_d[0] = in_vld;
        idx_d[0] = in_idx;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
        if (flush) vld_d = '0;
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    // Any valid entry that has not yet reached the output stage.
    always_comb begin
        pend_any = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pend_any = pend_any | vld_q[i];
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/enc_pack_sched.sv
// Binder-pack sequencer: walks the packs once per sample, strobes each pack's
// start_encoding as its level HVs arrive, and steers the bundling accumulator
// BIND_LAT cycles later. done pulses once the last pack has been accumulated.
module enc_pack_sched
    import enc_pack_sched_pkg::*;
#(
    parameter int NUM_PACKS       = NUM_PACKS_DEF,
    parameter int FEATURES_PER_CC = FEATURES_PER_CC_DEF,
    parameter int BIND_LAT        = BIND_LAT_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         abort,
    input  logic                                         level_valid,
    output logic [NUM_PACKS-1:0]                         pack_start,
    output logic [$clog2(NUM_PACKS*FEATURES_PER_CC)-1:0] feat_base,
    output logic                                         acc_clear,
    output logic                                         acc_en,
    output logic [$clog2(NUM_PACKS)-1:0]                 acc_sel,
    output logic                                         busy,
    output logic                                         done
);

    localparam int IDX_W = $clog2(NUM_PACKS);
    localparam int FB_W  = $clog2(NUM_PACKS*FEATURES_PER_CC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACKS - 1);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] pack_idx_q, pack_idx_d;
    logic [FB_W-1:0]  feat_base_q, feat_base_d;
    logic             acc_clear_q, acc_clear_d;
    logic             issue;
    logic             pend_any;

    // Next-state, pack walk and issue decision; abort/rst override everything.
    always_comb begin
        state_d     = state_q;
        pack_idx_d  = pack_idx_q;
        feat_base_d = feat_base_q;
        acc_clear_d = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ISSUE;
                    pack_idx_d  = '0;
                    feat_base_d = '0;
                    acc_clear_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (level_valid) begin
                    issue = 1'b1;
                    // Index saturates on the last pack; ISSUE ends instead of wrapping.
                    if (pack_idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end else begin
                        pack_idx_d  = pack_idx_q + 1'b1;
                        feat_base_d = feat_base_q + FB_W'(FEATURES_PER_CC);
                    end
                end
            end
            S_DRAIN: begin
                // The output stage is consumed this cycle, so only entries
                // behind it keep us draining.
                if (!pend_any) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort || rst) begin
            state_d     = S_IDLE;
            pack_idx_d  = '0;
            feat_base_d = '0;
            acc_clear_d = 1'b0;
            issue       = 1'b0;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pack_idx_q  <= '0;
            feat_base_q <= '0;
            acc_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_idx_q  <= pack_idx_d;
            feat_base_q <= feat_base_d;
            acc_clear_q <= acc_clear_d;
        end
    end

    // One-hot start_encoding for the pack currently being fetched.
    always_comb begin
        pack_start = '0;
        if (issue) pack_start[pack_idx_q] = 1'b1;
    end

    enc_lat_pipe #(
        .DEPTH (BIND_LAT),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort),
        .in_vld   (issue),
        .in_idx   (pack_idx_q),
        .out_vld  (acc_en),
        .out_idx  (acc_sel),
        .pend_any (pend_any)
    );

    assign feat_base = feat_base_q;
    assign acc_clear = acc_clear_q;
    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_enc_pack_sched.sv
// Bench for enc_pack_sched: two instances (8 packs / latency 1 and 4 packs /
// latency 3) share stimulus; a per-cycle reference model pushes expected
// output events into a queue and a negedge monitor pops and compares them.
module tb_enc_pack_sched;

    localparam int F = 62;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, abort = 1'b0, level_valid = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ps0;  logic [8:0] fb0;  logic [2:0] sel0;
    logic       clr0, en0, busy0, done0;
    logic [3:0] ps1;  logic [7:0] fb1;  logic [1:0] sel1;
    logic       clr1, en1, busy1, done1;

    enc_pack_sched #(.NUM_PACKS(8), .FEATURES_PER_CC(F), .BIND_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .level_valid(level_valid),
        .pack_start(ps0), .feat_base(fb0), .acc_clear(clr0), .acc_en(en0),
        .acc_sel(sel0), .busy(busy0), .done(done0));

    enc_pack_sched #(.NUM_PACKS(4), .FEATURES_PER_CC(F), .BIND_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .level_valid(level_valid),
        .pack_start(ps1), .feat_base(fb1), .acc_clear(clr1), .acc_en(en1),
        .acc_sel(sel1), .busy(busy1), .done(done1));

    // kind: 0 acc_clear, 1 pack_start (val = pack*1024 + feat_base), 2 acc_en (val = sel), 3 done
    typedef struct {int inst; int cyc; int kind; int val;} ev_t;
    typedef struct {int inst; int due; int pack;} pend_t;

    ev_t   expq[$];
    pend_t pend[$];
    int    np[2] = '{8, 4};
    int    lt[2] = '{1, 3};
    int    mst[2], midx[2];   // model: 0 idle, 1 issue, 2 drain, 3 done
    bit    mclr[2], mbusy[2];
    int    cyc = 0, checks = 0, failures = 0;
    int    done_cyc[2], done_cnt[2];
    bit    mon_en = 1'b0;
    string knm[4] = '{"acc_clear", "pack_start", "acc_en", "done"};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic void push_ev(input int i, input int k, input int v);
        ev_t e;
        e.inst = i; e.cyc = cyc; e.kind = k; e.val = v;
        expq.push_back(e);
    endfunction

    // Reference behaviour for one cycle of instance i, from the current inputs.
    task automatic model_step(input int i);
        bit    iss;
        int    left;
        pend_t p;
        if (mclr[i]) push_ev(i, 0, 0);
        mbusy[i] = (mst[i] == 1) || (mst[i] == 2);
        iss = (mst[i] == 1) && level_valid && !abort && !rst;
        if (iss) push_ev(i, 1, midx[i] * 1024 + midx[i] * F);
        for (int j = 0; j < pend.size(); j++)
            if (pend[j].inst == i && pend[j].due == cyc) begin
                push_ev(i, 2, pend[j].pack);
                pend.delete(j);
                break;
            end
        if (mst[i] == 3) push_ev(i, 3, 0);
        left = 0;
        foreach (pend[j]) if (pend[j].inst == i) left++;
        if (rst || abort) begin
            mst[i] = 0; midx[i] = 0; mclr[i] = 1'b0;
            for (int j = pend.size() - 1; j >= 0; j--)
                if (pend[j].inst == i) pend.delete(j);
        end else begin
            case (mst[i])
                0: begin
                    mclr[i] = start;
                    if (start) begin mst[i] = 1; midx[i] = 0; end
                end
                1: begin
                    mclr[i] = 1'b0;
                    if (iss) begin
                        p.inst = i; p.due = cyc + lt[i]; p.pack = midx[i];
                        pend.push_back(p);
                        if (midx[i] == np[i] - 1) mst[i] = 2;
                        else midx[i]++;
                    end
                end
                2: if (left == 0) mst[i] = 3;
                default: mst[i] = 0;
            endcase
        end
    endtask

    task automatic cyc_step(input bit s, input bit a, input bit lv, input bit r);
        @(posedge clk); #1;
        start = s; abort = a; level_valid = lv; rst = r;
        cyc++;
        model_step(0);
        model_step(1);
    endtask

    task automatic check_ev(input int i, input int kind, input int val);
        int j;
        j = -1;
        for (int n = 0; n < expq.size(); n++)
            if (expq[n].inst == i) begin j = n; break; end
        checks++;
        if (j < 0) begin
            failures++;
            $display("FAIL unexpected_%s inst=%0d cyc=%0d got=%0d want=none", knm[kind], i, cyc, val);
        end else begin
            if (expq[j].kind != kind || expq[j].cyc != cyc || expq[j].val != val) begin
                failures++;
                $display("FAIL %s inst=%0d got kind=%0d cyc=%0d val=%0d want kind=%0d cyc=%0d val=%0d",
                         knm[kind], i, kind, cyc, val, expq[j].kind, expq[j].cyc, expq[j].val);
            end
            expq.delete(j);
        end
    endtask

    task automatic observe(input int i, input logic clr, input logic [7:0] ps, input int fb,
                           input logic en, input int sel, input logic dn, input logic bz);
        int pidx;
        for (int j = expq.size() - 1; j >= 0; j--)
            if (expq[j].inst == i && expq[j].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missing_%s inst=%0d got=none want cyc=%0d val=%0d",
                         knm[expq[j].kind], i, expq[j].cyc, expq[j].val);
                expq.delete(j);
            end
        if (clr === 1'b1) check_ev(i, 0, 0);
        if (ps != 0) begin
            pidx = -1;
            if ($countones(ps) == 1)
                for (int b = 0; b < 8; b++) if (ps[b]) pidx = b;
            check_ev(i, 1, (pidx < 0) ? -1 : pidx * 1024 + fb);
        end
        if (en === 1'b1) check_ev(i, 2, sel);
        if (dn === 1'b1) begin
            check_ev(i, 3, 0);
            done_cyc[i] = cyc;
            done_cnt[i]++;
        end
        chk($sformatf("busy%0d", i), int'(bz), int'(mbusy[i]));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            observe(0, clr0, ps0, int'(fb0), en0, int'(sel0), done0, busy0);
            observe(1, clr1, {4'b0, ps1}, int'(fb1), en1, int'(sel1), done1, busy1);
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc_step(0, 0, 1, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ps0"}, int'(ps0), 0);  chk({tag, "_fb0"}, int'(fb0), 0);
        chk({tag, "_clr0"}, int'(clr0), 0); chk({tag, "_en0"}, int'(en0), 0);
        chk({tag, "_sel0"}, int'(sel0), 0); chk({tag, "_done0"}, int'(done0), 0);
        chk({tag, "_ps1"}, int'(ps1), 0);  chk({tag, "_en1"}, int'(en1), 0);
        chk({tag, "_sel1"}, int'(sel1), 0); chk({tag, "_busy1"}, int'(busy1), 0);
    endtask

    initial begin
        int s, d0;
        mst = '{0, 0}; midx = '{0, 0}; mclr = '{0, 0}; mbusy = '{0, 0};
        done_cyc = '{0, 0}; done_cnt = '{0, 0};
        cyc_step(0, 0, 0, 1);
        cyc_step(0, 0, 0, 1);
        mon_en = 1'b1;
        cyc_step(0, 0, 1, 0);
        @(negedge clk); #1;
        chk_reset_outputs("reset");

        // Level HVs always ready: done at +10 (8 packs, lat 1) and +8 (4 packs, lat 3).
        cyc_step(1, 0, 1, 0); s = cyc;
        idle(14);
        chk("done_cyc_basic0", done_cyc[0] - s, 10);
        chk("done_cyc_basic1", done_cyc[1] - s, 8);

        // Level HVs missing for three cycles after pack 2.
        cyc_step(1, 0, 1, 0); s = cyc;
        for (int k = 1; k <= 20; k++) cyc_step(0, 0, !(k >= 4 && k <= 6), 0);
        chk("done_cyc_stall0", done_cyc[0] - s, 13);
        chk("done_cyc_stall1", done_cyc[1] - s, 11);

        // Abort the cycle after pack_start[4], then a clean encode.
        cyc_step(1, 0, 1, 0); s = cyc; d0 = done_cnt[0];
        idle(5);
        cyc_step(0, 1, 1, 0);
        idle(12);
        chk("abort_no_done0", done_cnt[0] - d0, 0);
        cyc_step(1, 0, 1, 0);
        idle(14);

        // start during ISSUE and DONE is ignored; start+abort in IDLE stays idle.
        cyc_step(1, 0, 1, 0); s = cyc; d0 = done_cnt[0];
        idle(2);
        cyc_step(1, 0, 1, 0);
        idle(6);
        cyc_step(1, 0, 1, 0);
        idle(14);
        chk("ignored_start_dones0", done_cnt[0] - d0, 1);
        cyc_step(1, 1, 1, 0);
        cyc_step(0, 0, 1, 0);
        @(negedge clk); #1;
        chk("start_abort_busy0", int'(busy0), 0);
        chk("start_abort_busy1", int'(busy1), 0);
        idle(3);

        // Reset while the 4-pack instance drains.
        cyc_step(1, 0, 1, 0);
        idle(5);
        cyc_step(0, 0, 1, 1);
        cyc_step(0, 0, 1, 0);
        @(negedge clk); #1;
        chk_reset_outputs("midrst");
        idle(8);

        // Randomized traffic.
        for (int n = 0; n < 600; n++)
            cyc_step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        cyc_step(0, 1, 0, 0);
        idle(10);
        @(negedge clk); #1;
        foreach (expq[j]) begin
            checks++; failures++;
            $display("FAIL leftover_%s inst=%0d got=none want cyc=%0d val=%0d",
                     knm[expq[j].kind], expq[j].inst, expq[j].cyc, expq[j].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
